// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use, taken-branch and memory-wait stall/flush sequencing.
// Optional perf counters are enabled with `define HAZARD_PERF_CNT_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef LOAD
`define LOAD 7'b0000011
`endif

module hazard_unit #(
  parameter int XLEN              = `XLEN,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int FLUSH_STAGES      = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [XLEN-1:0]         i_if_id_instr,
  input  logic [XLEN-1:0]         i_id_ex_instr,
  input  logic                    i_taken_branch,
  input  logic                    i_mem_busy,
  output logic [4:0]              o_halt,
  output logic                    o_bubble_ex,
  output logic [FLUSH_STAGES-1:0] o_flush,
  output logic                    o_busy,
  output logic [31:0]             o_stall_count,
  output logic [15:0]             o_flush_count
);

  generate
    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 15) begin : g_bad_lsc
      $error("hazard_unit: LOAD_STALL_CYCLES must be 1..15");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_fc
      $error("hazard_unit: FLUSH_CYCLES must be 1..15");
    end
    if (FLUSH_STAGES < 1) begin : g_bad_fs
      $error("hazard_unit: FLUSH_STAGES must be at least 1");
    end
    if (XLEN < 32) begin : g_bad_xlen
      $error("hazard_unit: XLEN must be at least 32");
    end
  endgenerate

  localparam logic [6:0] OPC_LOAD   = `LOAD;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [3:0] LSC_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] FC_INIT  = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_STALL,
    S_FLUSH,
    S_MEM_WAIT
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  // Load-use detection on the decode/execute instruction pair
  logic [6:0] w_id_op;
  logic [4:0] w_rd;
  logic       w_use_rs1, w_use_rs2, w_lu;
  logic       w_unused;

  assign w_id_op   = i_if_id_instr[6:0];
  assign w_rd      = i_id_ex_instr[11:7];
  assign w_use_rs1 = !(w_id_op == OPC_LUI || w_id_op == OPC_AUIPC || w_id_op == OPC_JAL);
  assign w_use_rs2 = (w_id_op == OPC_OP) || (w_id_op == OPC_STORE) || (w_id_op == OPC_BRANCH);
  assign w_lu      = (i_id_ex_instr[6:0] == OPC_LOAD) && (w_rd != 5'd0) &&
                     ((w_use_rs1 && i_if_id_instr[19:15] == w_rd) ||
                      (w_use_rs2 && i_if_id_instr[24:20] == w_rd));
  assign w_unused  = ^{i_if_id_instr[XLEN-1:25], i_if_id_instr[14:7], i_id_ex_instr[XLEN-1:12]};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Events preempt in fixed priority; FLUSH ignores load-use since those instrs are squashed
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_mem_busy) begin
      w_state_nxt = S_MEM_WAIT;
    end else if (i_taken_branch) begin
      w_state_nxt = S_FLUSH;
      w_cnt_nxt   = FC_INIT;
    end else if (w_lu && (r_state == S_IDLE || r_state == S_LOAD_STALL)) begin
      w_state_nxt = S_LOAD_STALL;
      w_cnt_nxt   = LSC_INIT;
    end else begin
      case (r_state)
        S_LOAD_STALL, S_FLUSH: begin
          if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
          else               w_cnt_nxt   = r_cnt - 4'd1;
        end
        S_MEM_WAIT: w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_halt      = 5'b00000;
    o_bubble_ex = 1'b0;
    o_flush     = '0;
    case (r_state)
      S_LOAD_STALL: begin
        o_halt      = 5'b11000;
        o_bubble_ex = 1'b1;
      end
      S_FLUSH:    o_flush = '1;
      S_MEM_WAIT: o_halt  = 5'b11110;
      default:    ;
    endcase
  end

  assign o_busy = (r_state != S_IDLE);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_count;
  logic [15:0] r_flush_count;
  logic        w_flush_evt;

  // A branch while already flushing restarts the count and counts as a new flush
  assign w_flush_evt = i_taken_branch && !i_mem_busy;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_stall_count <= 32'd0;
      r_flush_count <= 16'd0;
    end else begin
      if (o_halt != 5'b00000 && r_stall_count != 32'hFFFF_FFFF)
        r_stall_count <= r_stall_count + 32'd1;
      if (w_flush_evt && r_flush_count != 16'hFFFF)
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;
`else
  assign o_stall_count = 32'd0;
  assign o_flush_count = 16'd0;
`endif

endmodule
